sigma_delta_dac_mc: RTL and testbench
=====================================

Name: sigma_delta_dac_mc

Overview:
Multi-channel, parametrised successor to the single-channel 8-bit audio sigma-delta DAC used at the board top level.
- Converts CHANNELS PCM samples of WIDTH bits into 1-bit pulse-density outputs for the board audio pins.
- Selectable 1st- or 2nd-order modulator and signed or unsigned input.
- Double-buffered sample load.
- Click-free mute via a per-channel slew ramp to midscale.
- Runs on the system clock, gated by the core clock enable (the run_nes tick).

Parameters:
CHANNELS, 2, number of independent channels (1..8)
WIDTH, 8, sample width in bits (4..16)
ORDER, 1, modulator order; 1 or 2, any other value is illegal
SIGNED_IN, 0, 1 = din is two's complement and is converted to offset binary by inverting its MSB at load
RAMP_STEP, 1, LSBs moved per tick while a mute/unmute ramp is in progress (1..2^(WIDTH-2))

Ports:
clock     in   1               system clock
reset_n   in   1               asynchronous active-low reset
cen       in   1               modulator tick enable; all state except the shadow registers advances only when cen=1
load      in   1               capture din into the shadow registers (sampled every clock, independent of cen)
din       in   CHANNELS*WIDTH  samples; channel k occupies bits [k*WIDTH +: WIDTH]
mute      in   1               1 = ramp all channels to midscale, 0 = ramp back to the shadow sample
dout      out  CHANNELS        1-bit PDM outputs, registered
settled   out  1               1 when no channel is ramping

Behaviour:
Definitions:
- MID = 2^(WIDTH-1).
- A "tick" is a clock edge with cen=1.

Reset (async, reset_n=0):
- dout=0, settled=1.
- shadow=MID, level=MID, ramping=0.
- All integrators=0.
- Deassertion is assumed synchronous to clock externally.

Load:
- On a clock edge with load=1: shadow_k <= din_k (MSB inverted if SIGNED_IN), whether or not cen=1.

Level update, per channel, on each tick:
- If ramping_k=0 and mute=0: level_k <= shadow_k. A load in the same cycle as a tick is not seen until the next tick.
- Ramp start: a change of mute (registered copy mute_q, updated on ticks only) sets ramping_k=1 for all channels. target = MID if mute, else shadow_k.
- While ramping_k=1:
  - level_k moves toward target by RAMP_STEP.
  - If |target-level_k| <= RAMP_STEP: level_k <= target and ramping_k <= 0.
- If mute toggles again mid-ramp, the target switches immediately; ramping stays set.
- While mute=1 and ramp complete: level_k holds MID.
- A shadow change while unmuted-ramping retargets to the new shadow.
- settled = NOR of ramping_k, registered.

ORDER=1 modulator, per channel, on each tick:
- sum = {1'b0,acc} + {1'b0,level} (WIDTH+1 bits).
- dout_k <= sum[WIDTH]; acc <= sum[WIDTH-1:0].
- Ones density is exactly level/2^WIDTH over any 2^WIDTH consecutive ticks with constant level.
- level=0 gives constant 0. level=MID gives 1,0,1,0... after the first tick from reset: ticks 1,2,3 give 0,1,0.

ORDER=2 modulator, per channel, on each tick:
- Integrator state: i1, i2 signed, WIDTH+4 bits.
- x = level - MID (signed).
- fb = dout_k ? +MID : -MID, using the current registered dout.
- i1' = sat(i1 + x - fb); i2' = sat(i2 + i1' - fb). sat clamps to the signed range; no wrap.
- dout_k <= (i2' >= 0).
- Density equals level/2^WIDTH within ±1/2^WIDTH over 2^(WIDTH+2) ticks.
- Constant level=0 or level=2^WIDTH-1 must not overflow; saturation is hit at most transiently.

Latency and gating:
- load at cycle t → level updated at the first tick after t → dout reflects it from the following tick.
- cen=0: dout, level, integrators, ramping and mute_q all hold.

Test Plan:
- Reset mid-stream: assert reset_n=0 asynchronously between clock edges → dout=0, settled=1 immediately; after release with cen=1 constantly and WIDTH=8, ORDER=1, no load, dout toggles 0,1,0,1.
- ORDER=1, WIDTH=8, load din ch0=0x40, ch1=0xFF, cen every 4th clock → over 1024 ticks, ch0 ones=256 and ch1 ones=1020 exactly.
- SIGNED_IN=1, WIDTH=8: load ch0=0x80 (-128), ch1=0x7F → levels 0x00 and 0xFF; ch0 dout stays 0 for all ticks.
- Mute ramp, RAMP_STEP=1: level=0xFF steady, mute 0→1 → settled low the cycle after the next tick, level decreases by 1 per tick, reaches 0x80 after 127 ticks; settled returns to 1; unmute ramps back to 0xFF in 127 ticks.
- Mute toggled back to 0 at tick 50 of that ramp → direction reverses immediately from 0xCD, back to 0xFF after 50 ticks; cen=0 for 100 clocks mid-ramp freezes level and dout.
- ORDER=2, WIDTH=8, level sweeping 0x00, 0x01, 0x80, 0xFE, 0xFF (1024 ticks each) → density within ±1/256 of level/256; no integrator wrap (assertion on saturation bounds).

Source files
------------

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta audio DAC: double-buffered samples, slew-limited
// mute toward midscale, and a 1st- or 2nd-order pulse-density modulator per channel.
module sigma_delta_dac_mc #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int ORDER     = 1,
    parameter int SIGNED_IN = 0,
    parameter int RAMP_STEP = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cen,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mute,
    output logic [CHANNELS-1:0]       dout,
    output logic                      settled
);
    localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] STEP      = WIDTH'(RAMP_STEP);
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED_IN != 0) ? MID : '0;

    logic [CHANNELS-1:0][WIDTH-1:0] level_q;
    logic [CHANNELS-1:0]            ramping_d;
    logic                           mute_q;
    logic                           mute_change;

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("sigma_delta_dac_mc: ORDER must be 1 or 2");
    end

    // Any edge of mute seen on a tick (re)starts the ramp on every channel.
    assign mute_change = mute ^ mute_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mute_q  <= 1'b0;
            settled <= 1'b1;
        end else if (cen) begin
            mute_q  <= mute;
            settled <= ~|ramping_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] shadow_r;
        logic [WIDTH-1:0] level_r;
        logic [WIDTH-1:0] level_n;
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] diff;
        logic             ramping_r;
        logic             ramping_n;
        logic             up;
        logic             dout_r;

        // The shadow register is the only state that updates without cen.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                shadow_r <= MID;
            end else if (load) begin
                shadow_r <= din[k*WIDTH +: WIDTH] ^ SIGN_FLIP;
            end
        end

        assign target = mute ? MID : shadow_r;
        assign up     = target > level_r;
        assign diff   = up ? target - level_r : level_r - target;

        always_comb begin
            level_n   = target;
            ramping_n = 1'b0;
            if ((ramping_r || mute_change) && diff > STEP) begin
                level_n   = up ? level_r + STEP : level_r - STEP;
                ramping_n = 1'b1;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                level_r   <= MID;
                ramping_r <= 1'b0;
            end else if (cen) begin
                level_r   <= level_n;
                ramping_r <= ramping_n;
            end
        end

        assign level_q[k]   = level_r;
        assign ramping_d[k] = ramping_n;
        assign dout[k]      = dout_r;

        if (ORDER == 2) begin : g_o2
            localparam int IW = WIDTH + 4;
            localparam int SW = WIDTH + 6;
            localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(IW-1){1'b1}}};
            localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(IW-1){1'b0}}};
            localparam logic signed [SW-1:0] FB_MAG  = {{(SW-WIDTH){1'b0}}, MID};

            logic signed [IW-1:0] i1_q;
            logic signed [IW-1:0] i2_q;
            logic signed [IW-1:0] i1_n;
            logic signed [IW-1:0] i2_n;
            logic signed [SW-1:0] x;
            logic signed [SW-1:0] fb;

            // Clamp rather than wrap so full-scale input cannot flip the loop sign.
            function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
                if (v > SAT_MAX) return SAT_MAX[IW-1:0];
                if (v < SAT_MIN) return SAT_MIN[IW-1:0];
                return v[IW-1:0];
            endfunction

            assign x    = $signed({{(SW-WIDTH){1'b0}}, level_r}) - FB_MAG;
            assign fb   = dout_r ? FB_MAG : -FB_MAG;
            assign i1_n = sat(SW'(i1_q) + x - fb);
            assign i2_n = sat(SW'(i2_q) + SW'(i1_n) - fb);

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    i1_q   <= '0;
                    i2_q   <= '0;
                    dout_r <= 1'b0;
                end else if (cen) begin
                    i1_q   <= i1_n;
                    i2_q   <= i2_n;
                    dout_r <= ~i2_n[IW-1];
                end
            end
        end else begin : g_o1
            logic [WIDTH-1:0] acc_q;
            logic [WIDTH:0]   sum;

            // The carry out of the phase accumulator is the pulse stream.
            assign sum = {1'b0, acc_q} + {1'b0, level_r};

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    acc_q  <= '0;
                    dout_r <= 1'b0;
                end else if (cen) begin
                    acc_q  <= sum[WIDTH-1:0];
                    dout_r <= sum[WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Bench for sigma_delta_dac_mc: three instances (unsigned 1st order, signed
// 1st order, unsigned 2nd order) share all inputs and are checked side by side.
`timescale 1ns/1ps
module tb_sigma_delta_dac_mc;
    localparam int CH = 2;
    localparam int W  = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cen = 1'b0;
    logic          load = 1'b0;
    logic          mute = 1'b0;
    logic [CH*W-1:0] din = '0;
    logic [CH-1:0] dout_o1, dout_sg, dout_o2;
    logic          settled_o1, settled_sg, settled_o2;

    int n_checks = 0;
    int n_errors = 0;
    logic [CH-1:0] exp_q[$];
    logic [CH-1:0] sb_exp;

    typedef struct {
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        int           o1_0;
        int           o1_1;
        int           sg_0;
        int           sg_1;
    } vec_t;
    vec_t vecs[4];

    sigma_delta_dac_mc #(.CHANNELS(CH), .WIDTH(W), .ORDER(1), .SIGNED_IN(0), .RAMP_STEP(1)) u_o1 (
        .clock(clock), .reset_n(reset_n), .cen(cen), .load(load), .din(din),
        .mute(mute), .dout(dout_o1), .settled(settled_o1)
    );
    sigma_delta_dac_mc #(.CHANNELS(CH), .WIDTH(W), .ORDER(1), .SIGNED_IN(1), .RAMP_STEP(1)) u_sg (
        .clock(clock), .reset_n(reset_n), .cen(cen), .load(load), .din(din),
        .mute(mute), .dout(dout_sg), .settled(settled_sg)
    );
    sigma_delta_dac_mc #(.CHANNELS(CH), .WIDTH(W), .ORDER(2), .SIGNED_IN(0), .RAMP_STEP(1)) u_o2 (
        .clock(clock), .reset_n(reset_n), .cen(cen), .load(load), .din(din),
        .mute(mute), .dout(dout_o2), .settled(settled_o2)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drivers: everything is driven 1 ns after a rising edge.
    task automatic idle(input int n);
        cen = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic tick();
        cen = 1'b1;
        @(posedge clock);
        #1;
        cen = 1'b0;
    endtask

    task automatic tick4();
        idle(3);
        tick();
    endtask

    task automatic do_load(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic with_tick);
        din  = {c1, c0};
        load = 1'b1;
        cen  = with_tick;
        @(posedge clock);
        #1;
        load = 1'b0;
        cen  = 1'b0;
    endtask

    // After reset with midscale level both channels must alternate 00,11,...
    task automatic sb_toggle_run(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back((i % 2 == 0) ? 2'b00 : 2'b11);
            idle($urandom_range(0, 3));
            tick();
        end
    endtask

    // Scoreboard: one expected dout word is consumed per tick while the queue holds entries.
    always @(posedge clock) begin
        if (reset_n && cen && exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            #2;
            check("sb_dout", int'(dout_o1), int'(sb_exp));
        end
    end

    initial begin
        int c_o1[CH];
        int c_sg[CH];
        int c_o2[CH];
        int changes;
        logic [CH-1:0] dout_hold;

        vecs[0] = '{d0: 8'h40, d1: 8'hFF, o1_0: 256,  o1_1: 1020, sg_0: 768, sg_1: 508};
        vecs[1] = '{d0: 8'h80, d1: 8'h7F, o1_0: 512,  o1_1: 508,  sg_0: 0,   sg_1: 1020};
        vecs[2] = '{d0: 8'h00, d1: 8'h01, o1_0: 0,    o1_1: 4,    sg_0: 512, sg_1: 516};
        vecs[3] = '{d0: 8'hFE, d1: 8'h80, o1_0: 1016, o1_1: 512,  sg_0: 504, sg_1: 0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_dout_o1", int'(dout_o1), 0);
        check("rst_dout_o2", int'(dout_o2), 0);
        check("rst_settled", int'(settled_o1), 1);
        check("rst_level", int'(u_o1.level_q[0]), 128);
        reset_n = 1'b1;
        idle(2);

        sb_toggle_run(6);

        // Load latency: shadow loads without cen, level follows on the next tick.
        do_load(8'h33, 8'h44, 1'b0);
        check("load_nocen_lvl0", int'(u_o1.level_q[0]), 128);
        tick();
        check("load_tick_lvl0", int'(u_o1.level_q[0]), 'h33);
        check("load_tick_lvl1", int'(u_o1.level_q[1]), 'h44);
        do_load(8'h55, 8'h66, 1'b1);
        check("load_same_tick_lvl0", int'(u_o1.level_q[0]), 'h33);
        tick();
        check("load_next_tick_lvl0", int'(u_o1.level_q[0]), 'h55);
        check("load_next_tick_lvl1", int'(u_o1.level_q[1]), 'h66);
        do_load(8'h80, 8'h7F, 1'b0);
        tick();
        check("signed_lvl0", int'(u_sg.level_q[0]), 'h00);
        check("signed_lvl1", int'(u_sg.level_q[1]), 'hFF);

        // Density table, cen every 4th clock.
        for (int v = 0; v < 4; v++) begin
            do_load(vecs[v].d0, vecs[v].d1, 1'b0);
            tick4();
            repeat (256) tick4();
            for (int c = 0; c < CH; c++) begin
                c_o1[c] = 0;
                c_sg[c] = 0;
                c_o2[c] = 0;
            end
            repeat (1024) begin
                tick4();
                for (int c = 0; c < CH; c++) begin
                    c_o1[c] += int'(dout_o1[c]);
                    c_sg[c] += int'(dout_sg[c]);
                    c_o2[c] += int'(dout_o2[c]);
                end
            end
            check("o1_ones_ch0", c_o1[0], vecs[v].o1_0);
            check("o1_ones_ch1", c_o1[1], vecs[v].o1_1);
            check("sg_ones_ch0", c_sg[0], vecs[v].sg_0);
            check("sg_ones_ch1", c_sg[1], vecs[v].sg_1);
            check_range("o2_ones_ch0", c_o2[0], 4 * int'(vecs[v].d0) - 4, 4 * int'(vecs[v].d0) + 4);
            check_range("o2_ones_ch1", c_o2[1], 4 * int'(vecs[v].d1) - 4, 4 * int'(vecs[v].d1) + 4);
        end

        // Mute ramp down and back up.
        do_load(8'hFF, 8'hFF, 1'b0);
        tick();
        check("pre_mute_lvl", int'(u_o1.level_q[0]), 'hFF);
        check("pre_mute_settled", int'(settled_o1), 1);
        mute = 1'b1;
        tick();
        check("mute_t1_settled", int'(settled_o1), 0);
        check("mute_t1_lvl", int'(u_o1.level_q[0]), 'hFE);
        repeat (125) tick();
        check("mute_t126_lvl", int'(u_o1.level_q[1]), 'h81);
        check("mute_t126_settled", int'(settled_o1), 0);
        tick();
        check("mute_t127_lvl", int'(u_o1.level_q[0]), 'h80);
        check("mute_t127_settled", int'(settled_o1), 1);
        tick();
        check("mute_hold_lvl", int'(u_o1.level_q[0]), 'h80);
        mute = 1'b0;
        repeat (126) tick();
        check("unmute_t126_lvl", int'(u_o1.level_q[0]), 'hFE);
        check("unmute_t126_settled", int'(settled_o1), 0);
        tick();
        check("unmute_t127_lvl", int'(u_o1.level_q[0]), 'hFF);
        check("unmute_t127_settled", int'(settled_o1), 1);

        // Reverse mid-ramp, with a long cen=0 freeze before the reversal is seen.
        mute = 1'b1;
        repeat (50) tick();
        check("rev_t50_lvl", int'(u_o1.level_q[0]), 'hCD);
        mute = 1'b0;
        dout_hold = dout_o1;
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (dout_o1 != dout_hold || u_o1.level_q[0] != 8'hCD || settled_o1 != 1'b0) changes++;
        end
        check("freeze_changes", changes, 0);
        tick();
        check("rev_first_lvl", int'(u_o1.level_q[0]), 'hCE);
        repeat (48) tick();
        check("rev_t49_lvl", int'(u_o1.level_q[1]), 'hFE);
        check("rev_t49_settled", int'(settled_o1), 0);
        tick();
        check("rev_t50_back_lvl", int'(u_o1.level_q[0]), 'hFF);
        check("rev_t50_settled", int'(settled_o1), 1);

        // Asynchronous reset between edges, then the toggle pattern again.
        mute = 1'b1;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_dout_o1", int'(dout_o1), 0);
        check("arst_dout_sg", int'(dout_sg), 0);
        check("arst_dout_o2", int'(dout_o2), 0);
        check("arst_settled", int'(settled_o1), 1);
        check("arst_lvl", int'(u_o1.level_q[1]), 128);
        mute = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1);
        sb_toggle_run(8);
        idle(2);
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
